// File: rtl/crc_enc_arbiter_pkg.sv
// Shared types and widths for the round-robin CRC encoder/serializer.
// Holds the FSM state encoding and the codeword geometry (3 data + 4 check bits).
package crc_enc_pkg;

  localparam int DATA_W = 3;
  localparam int CRC_W  = 4;
  localparam int CW_W   = DATA_W + CRC_W;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(CW_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/crc_enc_arbiter_crc_three.sv
// Combinational check-bit generator for a 3-bit data word; zero latency, no flow control.
// Output order is {c3,c2,c1,c0}.
module crc_three
  import crc_enc_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);

  assign o_crc = {i_data[2] ^ i_data[1],
                  i_data[1] ^ i_data[0],
                  ^i_data,
                  i_data[2] ^ i_data[0]};

endmodule

// File: rtl/crc_enc_arbiter.sv
// Two-requester round-robin arbiter feeding a 7-bit CRC codeword serializer, MSB first.
// Latency: first bit one cycle after acceptance; i_ser_ready low freezes the shifter in place.
module crc_enc_arbiter
  import crc_enc_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_ser_bit,
  output logic              o_ser_valid,
  output logic              o_ser_sof,
  output logic              o_ser_src,
  input  logic              i_ser_ready,
  output logic [7:0]        o_cw_count
);

  state_t            r_state, w_state_nxt;
  logic [CW_W-1:0]   r_cw, w_cw_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_src, w_src_nxt;
  logic              r_ptr, w_ptr_nxt;
  logic [7:0]        r_cw_count, w_cw_count_nxt;

  logic              w_grant_vld;
  logic              w_grant_idx;
  logic [DATA_W-1:0] w_grant_dat;
  logic [CRC_W-1:0]  w_crc;

  // Priority pointer only matters when both requesters contend.
  always_comb begin
    w_grant_vld = i_req0_valid | i_req1_valid;
    w_grant_idx = (i_req0_valid && i_req1_valid) ? r_ptr : i_req1_valid;
    w_grant_dat = w_grant_idx ? i_req1_data : i_req0_data;
  end

  crc_three u_crc (
    .i_data (w_grant_dat),
    .o_crc  (w_crc)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cw_nxt        = r_cw;
    w_cnt_nxt       = r_cnt;
    w_src_nxt       = r_src;
    w_ptr_nxt       = r_ptr;
    w_cw_count_nxt  = r_cw_count;
    o_req0_ready    = 1'b0;
    o_req1_ready    = 1'b0;
    o_ser_valid     = 1'b0;
    o_ser_bit       = 1'b0;
    o_ser_sof       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_rst && w_grant_vld) begin
          o_req0_ready = ~w_grant_idx;
          o_req1_ready = w_grant_idx;
          w_state_nxt  = ST_SHIFT;
          w_cw_nxt     = {w_grant_dat, w_crc};
          w_cnt_nxt    = CNT_FIRST;
          w_src_nxt    = w_grant_idx;
          w_ptr_nxt    = ~w_grant_idx;
        end
      end
      ST_SHIFT: begin
        o_ser_valid = 1'b1;
        o_ser_bit   = r_cw[CW_W-1];
        o_ser_sof   = (r_cnt == CNT_FIRST);
        if (i_ser_ready) begin
          w_cw_nxt  = {r_cw[CW_W-2:0], 1'b0};
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt    = ST_IDLE;
            w_cw_count_nxt = r_cw_count + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cw       <= '0;
      r_cnt      <= '0;
      r_src      <= 1'b0;
      r_ptr      <= 1'(RR_INIT);
      r_cw_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cw       <= w_cw_nxt;
      r_cnt      <= w_cnt_nxt;
      r_src      <= w_src_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cw_count <= w_cw_count_nxt;
    end
  end

  assign o_ser_src  = r_src;
  assign o_cw_count = r_cw_count;

endmodule

// File: tb/tb_crc_enc_arbiter.sv
// Directed scoreboard bench for crc_enc_arbiter: expected serial bits queued at acceptance,
// a negedge monitor pops and compares on every serial handshake.
module tb_crc_enc_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_req0_valid = 1'b0;
  logic [2:0] i_req0_data = 3'b000;
  logic       o_req0_ready;
  logic       i_req1_valid = 1'b0;
  logic [2:0] i_req1_data = 3'b000;
  logic       o_req1_ready;
  logic       o_ser_bit, o_ser_valid, o_ser_sof, o_ser_src;
  logic       i_ser_ready = 1'b1;
  logic [7:0] o_cw_count;

  always #5 i_clk = ~i_clk;

  crc_enc_arbiter #(.RR_INIT(0)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ready (o_req1_ready),
    .o_ser_bit    (o_ser_bit),
    .o_ser_valid  (o_ser_valid),
    .o_ser_sof    (o_ser_sof),
    .o_ser_src    (o_ser_src),
    .i_ser_ready  (i_ser_ready),
    .o_cw_count   (o_cw_count)
  );

  typedef struct packed {
    logic b;
    logic sof;
    logic src;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic mon_en = 1'b0;
  logic wrap_mode = 1'b0;
  logic saw_255 = 1'b0;
  int   cyc = 0;
  int   last_sof = -1;
  int   stalls = 0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor samples 2ns after the falling edge, once the negedge-driven inputs have settled.
  always @(negedge i_clk) begin
    #2;
    cyc++;
    if (mon_en && !i_rst) begin
      if (o_cw_count == 8'd255) saw_255 = 1'b1;
      if (o_ser_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit: got bit %0d with empty scoreboard", o_ser_bit);
        end else begin
          mon_e = exp_q[0];
          chk("ser_bit", 32'(o_ser_bit), 32'(mon_e.b));
          chk("ser_sof", 32'(o_ser_sof), 32'(mon_e.sof));
          chk("ser_src", 32'(o_ser_src), 32'(mon_e.src));
          if (wrap_mode && o_ser_sof) begin
            if (last_sof >= 0) chk("sof_period", 32'(cyc - last_sof), 32'd8);
            last_sof = cyc;
          end
          if (i_ser_ready) void'(exp_q.pop_front());
          else stalls++;
        end
      end else begin
        chk("idle_bit", 32'(o_ser_bit), 32'd0);
        chk("idle_sof", 32'(o_ser_sof), 32'd0);
      end
    end
  end

  task automatic offer(input int idx, input logic [2:0] d, input logic [6:0] cw);
    logic done = 1'b0;
    logic rdy;
    if (idx == 0) begin i_req0_valid = 1'b1; i_req0_data = d; end
    else begin i_req1_valid = 1'b1; i_req1_data = d; end
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      rdy = (idx == 0) ? o_req0_ready : o_req1_ready;
      if (rdy) begin
        @(posedge i_clk);
        for (int b = 6; b >= 0; b--) exp_q.push_back('{cw[b], (b == 6), idx[0]});
        acc_q.push_back(idx);
        done = 1'b1;
      end
      @(negedge i_clk);
    end
    if (idx == 0) i_req0_valid = 1'b0;
    else i_req1_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL offer_timeout: req%0d got no ready, required ready within 40 cycles", idx);
    end
  endtask

  task automatic wait_drain(input string name);
    logic ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge i_clk);
      #3;
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: %0d bits outstanding, required 0", name, exp_q.size());
    end
    @(negedge i_clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(o_req0_ready), 32'd0);
    chk("rst_ready1", 32'(o_req1_ready), 32'd0);
    @(negedge i_clk);
    #1;
    chk("rst_ready0_b", 32'(o_req0_ready), 32'd0);
    chk("rst_ready1_b", 32'(o_req1_ready), 32'd0);
    chk("rst_ser_valid", 32'(o_ser_valid), 32'd0);
    chk("rst_ser_src", 32'(o_ser_src), 32'd0);
    chk("rst_count", 32'(o_cw_count), 32'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int alt_err;
    do_reset();
    mon_en = 1'b1;

    // Single word from req0: 101 -> 1011100
    offer(0, 3'b101, 7'b1011100);
    wait_drain("single");
    chk("single_count", 32'(o_cw_count), 32'd1);

    // Contention from reset, priority starts with req0
    do_reset();
    fork
      offer(0, 3'b011, 7'b0111001);
      offer(1, 3'b111, 7'b1110010);
    join
    wait_drain("contend");
    chk("contend_n", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      chk("contend_first", 32'(acc_q[0]), 32'd0);
      chk("contend_second", 32'(acc_q[1]), 32'd1);
    end
    chk("contend_count", 32'(o_cw_count), 32'd2);

    // Backpressure on the fourth bit of 1110010
    stalls = 0;
    offer(1, 3'b111, 7'b1110010);
    repeat (3) @(negedge i_clk);
    i_ser_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    i_ser_ready = 1'b1;
    wait_drain("bp");
    chk("bp_stalls", 32'(stalls), 32'd3);
    chk("bp_count", 32'(o_cw_count), 32'd3);

    // Reset after the third bit of 1011100
    do_reset();
    offer(0, 3'b101, 7'b1011100);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    chk("midrst_valid", 32'(o_ser_valid), 32'd0);
    chk("midrst_count", 32'(o_cw_count), 32'd0);
    chk("midrst_abandoned", 32'(exp_q.size()), 32'd4);
    exp_q.delete();
    i_rst = 1'b0;
    @(negedge i_clk);
    #1;
    chk("midrst_idle", 32'(o_ser_valid), 32'd0);
    offer(0, 3'b101, 7'b1011100);
    wait_drain("midrst");
    chk("midrst_count2", 32'(o_cw_count), 32'd1);

    // 256 zero words, both requesters always offering
    do_reset();
    saw_255 = 1'b0;
    last_sof = -1;
    wrap_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 128; i++) offer(0, 3'b000, 7'b0000000);
      end
      begin
        for (int j = 0; j < 128; j++) offer(1, 3'b000, 7'b0000000);
      end
    join
    wait_drain("wrap");
    wrap_mode = 1'b0;
    chk("wrap_count", 32'(o_cw_count), 32'd0);
    chk("wrap_saw_255", 32'(saw_255), 32'd1);
    chk("wrap_n", 32'(acc_q.size()), 32'd256);
    alt_err = 0;
    for (int k = 1; k < acc_q.size(); k++) if (acc_q[k] == acc_q[k-1]) alt_err++;
    chk("wrap_alternate", 32'(alt_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
